// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer
//
// Issue stage that sits directly in front of a 32-bit combinational ALU.
// Requests {command, operandA, operandB} are buffered in a small FIFO and
// issued one at a time onto registered ALU inputs. After a fixed number of
// settle edges the ALU result and flags are captured into an output register
// and offered downstream over a valid/ready handshake. The ALU does not drive
// a zero flag, so it is derived here from the captured result.
//
// Parameters
//   FIFO_DEPTH     request FIFO entries (power of two, >= 2)
//   SETTLE_CYCLES  edges the ALU inputs are held before capture (>= 1)
//
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   in_valid / in_ready             request handshake
//   in_command/operandA/operandB    request payload
//   alu_command/operandA/operandB   registered ALU inputs
//   alu_result/carryout/overflow    combinational ALU outputs
//   out_valid / out_ready           result handshake
//   out_result/carryout/overflow    captured ALU outputs
//   out_zero                        captured result == 0
//   out_command                     command that produced the result
//   busy                            request in flight or FIFO non-empty

module alu_issue_sequencer #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_command,
    input  logic [31:0] in_operandA,
    input  logic [31:0] in_operandB,

    output logic [2:0]  alu_command,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_overflow,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_carryout,
    output logic        out_overflow,
    output logic        out_zero,
    output logic [2:0]  out_command,

    output logic        busy
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYCLES - 1);
    localparam logic [OccW-1:0] OccFull    = OccW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold
    } state_e;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [2:0]  fifo_cmd_q [FIFO_DEPTH];
    logic [31:0] fifo_a_q   [FIFO_DEPTH];
    logic [31:0] fifo_b_q   [FIFO_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0] occ_q, occ_d;

    logic push;
    logic pop;
    logic fifo_empty;

    // Readiness looks only at the registered occupancy, so a pop on the same
    // edge never makes room for a push.
    assign in_ready   = !reset && (occ_q != OccFull);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (occ_q == '0);

    // Storage is not reset; validity is tracked entirely by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd_q[wr_ptr_q] <= in_command;
            fifo_a_q[wr_ptr_q]   <= in_operandA;
            fifo_b_q[wr_ptr_q]   <= in_operandB;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue FSM and datapath registers
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [SetW-1:0] settle_q, settle_d;

    logic [2:0]  alu_cmd_q, alu_cmd_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic        out_carry_q, out_carry_d;
    logic        out_ovf_q, out_ovf_d;
    logic        out_zero_q, out_zero_d;
    logic [2:0]  out_cmd_q, out_cmd_d;

    logic capture;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        capture     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Head is only visible once it is in the FIFO, so a push into
                // an empty FIFO is issued on the following edge.
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    settle_d = SettleLoad;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SetW'(1);
                end else begin
                    capture     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        settle_d = SettleLoad;
                        state_d  = StSettle;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ALU inputs change only on a pop, so they stay glitch-free while the
    // ALU settles and while the result waits downstream.
    always_comb begin
        alu_cmd_d = alu_cmd_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        if (pop) begin
            alu_cmd_d = fifo_cmd_q[rd_ptr_q];
            alu_a_d   = fifo_a_q[rd_ptr_q];
            alu_b_d   = fifo_b_q[rd_ptr_q];
        end
    end

    // Output registers move only on the capture edge; flags pass through
    // untouched for every command.
    always_comb begin
        out_result_d = out_result_q;
        out_carry_d  = out_carry_q;
        out_ovf_d    = out_ovf_q;
        out_zero_d   = out_zero_q;
        out_cmd_d    = out_cmd_q;
        if (capture) begin
            out_result_d = alu_result;
            out_carry_d  = alu_carryout;
            out_ovf_d    = alu_overflow;
            out_zero_d   = (alu_result == 32'h0);
            out_cmd_d    = alu_cmd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            state_q      <= StIdle;
            settle_q     <= '0;
            alu_cmd_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_zero_q   <= 1'b0;
            out_cmd_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            state_q      <= state_d;
            settle_q     <= settle_d;
            alu_cmd_q    <= alu_cmd_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_carry_q  <= out_carry_d;
            out_ovf_q    <= out_ovf_d;
            out_zero_q   <= out_zero_d;
            out_cmd_q    <= out_cmd_d;
        end
    end

    assign alu_command  = alu_cmd_q;
    assign alu_operandA = alu_a_q;
    assign alu_operandB = alu_b_q;

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_carryout = out_carry_q;
    assign out_overflow = out_ovf_q;
    assign out_zero     = out_zero_q;
    assign out_command  = out_cmd_q;

    assign busy = (state_q != StIdle) || !fifo_empty;

endmodule
